// File: rtl/rx_buffer_ctrl.sv
// Receive-side byte buffer: FIFO between a UART-style receiver and a valid/ready stream,
// with framing-error clear handshake and saturating error-event counters.
module rx_buffer_ctrl #(
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      flush,
    input  logic [7:0]                rx_data,
    input  logic                      rx_data_valid,
    input  logic                      framing_err,
    input  logic                      overrun,
    output logic                      host_ready,
    output logic                      clear_framing_err,
    output logic [7:0]                m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [CNT_WIDTH-1:0]      ferr_count,
    output logic [CNT_WIDTH-1:0]      ovr_count,
    input  logic                      cnt_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FERR_CLR} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          push, pop;
    state_t        state;
    logic          cfe_q;
    logic          ovr_q;
    logic          ferr_entry, ovr_rise;

    // Full is judged on the registered count, so a pop while full frees space only next cycle.
    assign host_ready = en & ~flush & ~rst & (fifo_count < FULL);
    assign m_valid    = (fifo_count != '0) & ~rst;
    assign m_data     = (fifo_count != '0) ? mem[rptr] : 8'h00;
    assign push       = rx_data_valid & host_ready;
    assign pop        = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign ferr_entry        = (state != FERR_CLR) & framing_err;
    assign clear_framing_err = cfe_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cfe_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (framing_err) begin
                        state <= FERR_CLR;
                        cfe_q <= 1'b1;
                    end else if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (framing_err) begin
                        state <= FERR_CLR;
                        cfe_q <= 1'b1;
                    end else if (!en) begin
                        state <= IDLE;
                    end
                end
                FERR_CLR: begin
                    if (!framing_err) begin
                        state <= en ? RUN : IDLE;
                        cfe_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cfe_q <= 1'b0;
                end
            endcase
        end
    end

    assign ovr_rise = overrun & ~ovr_q;

    // Clear wins over the old value but a coincident event still counts as one.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] c,
                                                      input logic inc, input logic clr);
        if (clr)
            return inc ? CNT_WIDTH'(1) : '0;
        if (inc && (c != '1))
            return c + CNT_WIDTH'(1);
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q      <= 1'b0;
            ferr_count <= '0;
            ovr_count  <= '0;
        end else begin
            ovr_q      <= overrun;
            ferr_count <= cnt_next(ferr_count, ferr_entry, cnt_clear);
            ovr_count  <= cnt_next(ovr_count, ovr_rise, cnt_clear);
        end
    end

endmodule

// File: doc/rx_buffer_ctrl.md
RX_BUFFER_CTRL -- requirements
Module: rx_buffer_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO depth in bytes (power of 2, >= 2).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning width of each error counter.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  enables acceptance of bytes from the receiver.
REQ-006 SHALL have port flush  input  1  discards all FIFO contents.
REQ-007 SHALL have port rx_data  input  8  byte from the receiver.
REQ-008 SHALL have port rx_data_valid  input  1  receiver holds a byte.
REQ-009 SHALL have port framing_err  input  1  sticky framing error from the receiver.
REQ-010 SHALL have port overrun  input  1  receiver overrun level.
REQ-011 SHALL have port host_ready  output  1  permits the receiver to hand over its byte.
REQ-012 SHALL have port clear_framing_err  output  1  clears the receiver's sticky framing error.
REQ-013 SHALL have ports m_data  output  8, m_valid  output  1, m_ready  input  1, forming the downstream valid/ready stream.
REQ-014 SHALL have port fifo_count  output  $clog2(DEPTH)+1  number of bytes held.
REQ-015 SHALL have ports ferr_count and ovr_count  output  CNT_WIDTH  error event counters, plus cnt_clear  input  1  which zeroes both.

Function
REQ-016 A receive transfer SHALL occur in a cycle where rx_data_valid=1 and host_ready=1; rx_data SHALL be written to the FIFO tail at that edge.
REQ-017 host_ready SHALL be en & ~flush & ~rst & (fifo_count < DEPTH), decoded from registered state plus these inputs, with no combinational path from rx_data_valid or m_ready.
REQ-018 A downstream transfer SHALL occur when m_valid=1 and m_ready=1; the FIFO head SHALL be popped at that edge.
REQ-019 m_valid SHALL equal (fifo_count != 0); m_data SHALL present the head entry and stay stable while m_valid=1 and m_ready=0.
REQ-020 Latency: a byte received at edge N SHALL appear on m_data with m_valid=1 in cycle N+1 when the FIFO was empty.
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-022 When full, a same-cycle pop SHALL NOT raise host_ready in that cycle; space becomes visible the next cycle.
REQ-023 flush=1 SHALL zero fifo_count and both pointers at the next edge; any pop that cycle has no further effect.
REQ-024 The FSM SHALL have states IDLE, RUN, and FERR_CLR; it SHALL reset to IDLE.
REQ-025 The FSM transitions SHALL be: IDLE->RUN when en=1; RUN->IDLE when en=0; IDLE or RUN->FERR_CLR when framing_err=1 (takes priority); FERR_CLR->RUN when framing_err=0 & en=1; FERR_CLR->IDLE when framing_err=0 & en=0.
REQ-026 clear_framing_err SHALL be 1 exactly while in FERR_CLR and 0 otherwise.
REQ-027 FIFO push/pop SHALL continue unaffected in all FSM states; only host_ready gating applies.
REQ-028 ferr_count SHALL increment by 1 on each transition into FERR_CLR.
REQ-029 ovr_count SHALL increment by 1 on each rising edge of overrun, detected against a registered copy of overrun that resets to 0.
REQ-030 Both counters SHALL saturate at 2^CNT_WIDTH-1.
REQ-031 cnt_clear=1 SHALL load 0 into both counters; a same-cycle increment SHALL load 1 instead.
REQ-032 Deasserting en mid-stream SHALL drop host_ready in the same cycle, retain FIFO contents, and keep the FIFO drainable.

Reset
REQ-033 While rst=1, host_ready, clear_framing_err, and m_valid SHALL be 0.
REQ-034 At the first edge with rst=1: fifo_count, pointers, ferr_count, ovr_count, and the overrun history SHALL be 0, the FSM SHALL be IDLE, and m_data SHALL be 8'h00.
REQ-035 Reset asserted mid-operation SHALL discard FIFO contents and any pending FERR_CLR with no partial state retained.

Verification
REQ-036 Scenario: en=1, push 0x41,0x42,0x43 with m_ready=0 -> fifo_count=3, m_data=0x41; then m_ready=1 for 3 cycles -> outputs 0x41,0x42,0x43 in order, m_valid=0 afterward.
REQ-037 Scenario: DEPTH=8, push 8 bytes with m_ready=0 -> host_ready=0 at count 8; pop+valid in the same cycle -> no push that cycle, host_ready=1 the next.
REQ-038 Scenario: framing_err rises in RUN -> clear_framing_err=1 the next cycle, ferr_count=1; framing_err falls -> return to RUN with clear_framing_err=0.
REQ-039 Scenario: overrun high for 5 cycles twice -> ovr_count=2; with CNT_WIDTH=2 and 5 pulses -> ovr_count=3 (saturated).
REQ-040 Scenario: count=4 plus flush with rx_data_valid=1 -> host_ready=0, fifo_count=0 next cycle, no byte stored.
REQ-041 Scenario: rst for 1 cycle while full and in FERR_CLR -> all outputs at reset values, FSM IDLE; en=1 -> normal receive resumes.
